fetch_queue_unit: RTL and testbench
===================================

# fetch_queue_unit

Parametrised instruction fetch front end that issues sequential fetch requests over a valid/ready memory port. It keeps up to MAX_OUTST requests in flight and buffers in-order responses in a DEPTH-entry queue. Instructions go to decode over a valid/ready port. It sits between the instruction memory and the decode stage. A redirect from branch resolution or a predictor flushes the queue and discards stale in-flight responses. Erroring responses are reported as faulting entries and halt issue until the next redirect.

## Interface
Parameters:
- ADDR_W, 32, address and PC width
- INSTR_W, 32, instruction width; PC increment is INSTR_W/8
- DEPTH, 8, queue entries; must be a power of two, ≥2
- MAX_OUTST, 4, maximum in-flight memory requests; ≤DEPTH
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous and active-high
- mem_req_valid  out  1  fetch request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  ADDR_W  fetch address
- mem_resp_valid  in  1  response valid; in order, always accepted
- mem_resp_data  in  INSTR_W  instruction word
- mem_resp_err  in  1  access error for this response
- out_valid  out  1  queue head valid
- out_ready  in  1  decode consumes the head
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  head PC
- out_fault  out  1  head carries an access error
- redirect  in  1  flush and restart fetch
- redirect_pc  in  ADDR_W  new fetch PC
- stall  in  1  suppress new requests; responses and output unaffected
- faulted  out  1  unit is in FAULT state
- q_count  out  $clog2(DEPTH+1)  occupied queue entries

## Operation
- Registers:
  - fetch_pc: next request address.
  - resp_pc: PC of the next expected response.
  - outst: in-flight request count.
  - drop: responses still to discard.
  - state: RUN or FAULT.
- Issue condition: mem_req_valid = (state==RUN) && !stall && !redirect && (q_count + outst < DEPTH) && (outst < MAX_OUTST).
- Request fire (valid && ready): fetch_pc += INSTR_W/8, wrapping modulo 2^ADDR_W; outst++.
- Response handling:
  - Every response decrements outst.
  - If drop>0, the response is discarded and drop decrements.
  - Otherwise {resp_pc, data, err} is pushed into the queue and resp_pc += INSTR_W/8.
  - The credit check guarantees the queue never overflows. A push to a full queue is a design error and is asserted against.
- Fault: a pushed response with err=1 moves the FSM RUN→FAULT. In FAULT no requests issue and `faulted`=1. Outstanding responses are still accepted, but those behind the fault are discarded. The queue continues to drain.
- Redirect (one-cycle pulse, highest priority):
  - Flushes the queue; a simultaneous pop is ignored.
  - Sets fetch_pc and resp_pc to redirect_pc.
  - Sets drop to the number of responses still owed after this cycle: outst plus any fire this cycle (fire is suppressed, so zero) minus any response this cycle.
  - Discards any response arriving in the same cycle.
  - Sets the FSM to RUN.
- Pop: out_valid && out_ready removes the head.
- A push and a pop in the same cycle leave q_count unchanged.

## Timing
- Reset values:
  - mem_req_valid=0 while rst is high; mem_req_addr=RESET_PC.
  - out_valid=0, out_instr=0, out_pc=0, out_fault=0, faulted=0, q_count=0.
  - outst=0, drop=0, state=RUN.
- First request valid in the first cycle after rst deasserts.
- Asserting rst mid-operation clears all state immediately. In-flight responses are the memory's responsibility to cancel.
- Latency: a response at edge N is visible on out_* from cycle N+1. Queue-to-output is a registered FIFO head with no bypass.
- Redirect at edge N:
  - out_valid=0 in cycle N+1.
  - mem_req_addr=redirect_pc in cycle N+1.
  - A request may issue in N+1 if credits allow.
- Back-to-back requests: one per cycle when ready is held high and credits remain.
- mem_req_addr and mem_req_valid must stay stable while valid && !ready, except when a redirect or stall arrives.

## Structure
- fetch_pkg holds:
  - typedef fetch_entry_t {pc, instr, fault}, parametrised via package localparams.
  - typedef fetch_state_e {RUN, FAULT}.
  - Constant INSTR_BYTES.
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, count, full and empty. Pointers are wrap-around, one bit wider than the index.
- The top holds the PC registers, credit/drop counters and FSM.

## Test plan
- Reset, then ready=1, resp returned 2 cycles after each request, out_ready=1 → PCs 0x0, 0x4, 0x8… appear in order; outst never exceeds MAX_OUTST=4.
- out_ready=0, memory always responsive → q_count reaches 8 and requests stop. Invariant q_count+outst ≤ 8 holds; there is no overflow.
- 3 requests in flight, redirect to 0x100 → next 3 responses are discarded. The first out_pc after the redirect is 0x100.
- Redirect in the same cycle as a response and a pop → response dropped, queue empty next cycle, drop = outst−1.
- Response with err=1 at PC 0x8 → entry out_fault=1, faulted=1, no further requests. A later redirect to 0x40 restores RUN and fetch resumes from 0x40.
- stall=1 for 5 cycles with mem_req_ready=0 → no request fires. Address is held, and fetch resumes at the same PC when stall drops.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
//   fetch_entry_t : one queue entry {pc, instr, fault}
//   fetch_state_e : issue FSM state (RUN / FAULT)
//   INSTR_BYTES   : PC increment per fetched instruction
package fetch_pkg;

  localparam int FQ_ADDR_W   = 32;
  localparam int FQ_INSTR_W  = 32;
  localparam int INSTR_BYTES = FQ_INSTR_W / 8;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [FQ_ADDR_W-1:0]  pc;
    logic [FQ_INSTR_W-1:0] instr;
    logic                  fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bus bundle of the fetch unit: memory request/response channel plus the
// decode-side output channel.
//   master : the fetch unit (drives requests and decode output)
//   slave  : memory + decode stage
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FQ_ADDR_W,
  parameter int INSTR_W = FQ_INSTR_W
);

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_resp_valid;
  logic [INSTR_W-1:0] mem_resp_data;
  logic               mem_resp_err;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               out_fault;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_data, mem_resp_err,
    output out_valid, out_instr, out_pc, out_fault,
    input  out_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_data, mem_resp_err,
    input  out_valid, out_instr, out_pc, out_fault,
    output out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch_entry_t.
//   push/push_data : write an entry
//   pop            : remove the head (ignored when empty)
//   flush          : empty the FIFO, overrides push and pop
//   head           : current head entry, zero while empty
//   count/full/empty : occupancy
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 push_data,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_pop;
  fetch_entry_t mem [DEPTH];

  assign do_pop = pop && !empty;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array has no reset; only the pointers do. Stale data
  // is never visible because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_queue_unit.sv
// Sequential instruction fetch front end.
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : fetch_if.master (memory req/resp + decode output)
//   redirect     : one-cycle flush, restart fetch at redirect_pc
//   stall        : suppress new requests only
//   faulted      : unit halted on an erroring response
//   q_count      : occupied queue entries
// Credits: a request issues only while queued entries plus in-flight
// requests leave room in the queue, so every response has a slot.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = FQ_ADDR_W,
  parameter int                INSTR_W   = FQ_INSTR_W,
  parameter int                DEPTH     = 8,
  parameter int                MAX_OUTST = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  fetch_if.master                    bus,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       stall,
  output logic                       faulted,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(MAX_OUTST+1);
  localparam int SW = CW + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, resp_pc_q;
  logic [OW-1:0]     outst_q, outst_d, drop_q;
  logic [SW-1:0]     credit_use;
  logic              fire, push, pop, q_full, q_empty;
  fetch_entry_t      push_entry, head;

  assign credit_use = SW'(q_count) + SW'(outst_q);

  assign bus.mem_req_valid = !rst && (state_q == RUN) && !stall && !redirect &&
                             (credit_use < SW'(DEPTH)) && (outst_q < OW'(MAX_OUTST));
  assign bus.mem_req_addr  = fetch_pc_q;
  assign fire = bus.mem_req_valid && bus.mem_req_ready;

  // Responses are discarded while draining stale ones, behind a fault, or
  // in the redirect cycle itself.
  assign push = bus.mem_resp_valid && !redirect && (drop_q == '0) && (state_q == RUN);
  assign pop  = bus.out_valid && bus.out_ready && !redirect;

  // After a redirect this is exactly the number of stale responses still owed.
  assign outst_d = outst_q + OW'(fire) - OW'(bus.mem_resp_valid);

  assign push_entry = '{pc:    FQ_ADDR_W'(resp_pc_q),
                        instr: FQ_INSTR_W'(bus.mem_resp_data),
                        fault: bus.mem_resp_err};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_data (push_entry),
    .head      (head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign bus.out_valid = !q_empty;
  assign bus.out_instr = INSTR_W'(head.instr);
  assign bus.out_pc    = ADDR_W'(head.pc);
  assign bus.out_fault = head.fault;
  assign faulted       = (state_q == FAULT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
    end else if (redirect) begin
      fetch_pc_q <= redirect_pc;
      resp_pc_q  <= redirect_pc;
    end else begin
      if (fire) fetch_pc_q <= fetch_pc_q + PC_STEP;
      if (push) resp_pc_q  <= resp_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      outst_q <= outst_d;
      if (redirect)                                 drop_q <= outst_d;
      else if (bus.mem_resp_valid && drop_q != '0) drop_q <= drop_q - OW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // NOTE: next-state defaults to hold before any branch so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (redirect)                      state_d = RUN;
    else if (push && bus.mem_resp_err) state_d = FAULT;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && q_full));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit. A memory model answers requests
// in order after resp_lat cycles; a scoreboard queue holds the PCs expected
// at the decode port, cleared on redirect and behind a faulting entry.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fetch_queue_unit;
  import fetch_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int INSTR_W   = 32;
  localparam int DEPTH     = 8;
  localparam int MAX_OUTST = 4;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        faulted;
  logic [3:0]  q_count;

  fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  fetch_queue_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH),
    .MAX_OUTST(MAX_OUTST), .RESET_PC(32'h0)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .faulted     (faulted),
    .q_count     (q_count)
  );

  always #5 clk = ~clk;

  mreq_t       pend[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc, resp_lat, pop_count, fire_count;
  logic        mem_ready, out_rdy, exp_faulted, prev_pend, coll;
  logic [31:0] err_addr, model_pc, prev_addr, last_pop_pc, last_fire_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  // One clock cycle: present memory response, sample, update models.
  task automatic cycle();
    logic        rsp, fire_s, pop_s;
    logic [31:0] e;
    bus.mem_req_ready  = mem_ready;
    bus.out_ready      = out_rdy;
    rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    bus.mem_resp_valid = rsp;
    bus.mem_resp_data  = rsp ? instr_of(pend[0].addr) : 32'h0;
    bus.mem_resp_err   = rsp && (pend[0].addr == err_addr);
    #1;
    fire_s = bus.mem_req_valid && bus.mem_req_ready;
    pop_s  = bus.out_valid && bus.out_ready && !redirect;

    checks++;
    if (pend.size() > MAX_OUTST || int'(q_count) + pend.size() > DEPTH) begin
      failures++;
      $display("FAIL credit: q_count=%0d outst=%0d, required outst<=%0d and sum<=%0d",
               q_count, pend.size(), MAX_OUTST, DEPTH);
    end

    if (prev_pend && !redirect && !stall) begin
      checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== prev_addr) begin
        failures++;
        $display("FAIL req_hold: valid=%b addr=%h, required valid=1 addr=%h",
                 bus.mem_req_valid, bus.mem_req_addr, prev_addr);
      end
    end
    prev_pend = bus.mem_req_valid && !bus.mem_req_ready;
    prev_addr = bus.mem_req_addr;

    if (exp_faulted && !redirect) begin
      checks++;
      if (bus.mem_req_valid !== 1'b0 || faulted !== 1'b1) begin
        failures++;
        $display("FAIL fault_hold: valid=%b faulted=%b, required valid=0 faulted=1",
                 bus.mem_req_valid, faulted);
      end
    end

    if (pop_s) begin
      pop_count++;
      last_pop_pc = bus.out_pc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: got pc=%h, required no output", bus.out_pc);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_pc !== e || bus.out_instr !== instr_of(e) ||
            bus.out_fault !== (e == err_addr)) begin
          failures++;
          $display("FAIL sb_entry: pc=%h instr=%h fault=%b, required pc=%h instr=%h fault=%b",
                   bus.out_pc, bus.out_instr, bus.out_fault, e, instr_of(e), (e == err_addr));
        end
        if (e == err_addr) begin
          exp_q.delete();
          exp_faulted = 1'b1;
        end
      end
    end

    if (redirect) begin
      coll = rsp && bus.out_valid && bus.out_ready;
      exp_q.delete();
      exp_faulted = 1'b0;
      model_pc = redirect_pc;
    end

    if (rsp) void'(pend.pop_front());

    if (fire_s) begin
      fire_count++;
      last_fire_addr = bus.mem_req_addr;
      checks++;
      if (bus.mem_req_addr !== model_pc) begin
        failures++;
        $display("FAIL req_addr: addr=%h, required %h", bus.mem_req_addr, model_pc);
      end
      exp_q.push_back(model_pc);
      pend.push_back('{model_pc, cyc + resp_lat});
      model_pc = model_pc + 32'd4;
    end

    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    mem_ready = 1'b0; out_rdy = 1'b0;
    bus.mem_req_ready = 1'b0; bus.out_ready = 1'b0;
    bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 32'h0; bus.mem_resp_err = 1'b0;
    pend.delete(); exp_q.delete();
    model_pc = 32'h0; exp_faulted = 1'b0; prev_pend = 1'b0; coll = 1'b0;
    err_addr = 32'hFFFF_FFFF; resp_lat = 2; pop_count = 0; fire_count = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    bus.mem_req_ready = 1'b0; bus.out_ready = 1'b1;
    bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 32'h0; bus.mem_resp_err = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_req: valid=%b addr=%h, required 0 / 00000000",
               bus.mem_req_valid, bus.mem_req_addr);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.out_pc !== 32'h0 ||
        bus.out_fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: valid=%b instr=%h pc=%h fault=%b, required all zero",
               bus.out_valid, bus.out_instr, bus.out_pc, bus.out_fault);
    end
    checks++;
    if (faulted !== 1'b0 || q_count !== 4'd0) begin
      failures++;
      $display("FAIL reset_status: faulted=%b q_count=%0d, required 0/0", faulted, q_count);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL first_req: valid=%b addr=%h, required 1 / 00000000",
               bus.mem_req_valid, bus.mem_req_addr);
    end
  endtask

  task automatic test_stream();
    int f0;
    do_reset();
    mem_ready = 1'b1; out_rdy = 1'b1; resp_lat = 2;
    repeat (5) cycle();
    f0 = fire_count;
    repeat (20) cycle();
    checks++;
    if (fire_count - f0 != 20) begin
      failures++;
      $display("FAIL back_to_back: fires=%0d in 20 cycles, required 20", fire_count - f0);
    end
    repeat (10) cycle();
    checks++;
    if (pop_count < 25) begin
      failures++;
      $display("FAIL stream_pops: pops=%0d, required >=25", pop_count);
    end
  endtask

  task automatic test_fill();
    do_reset();
    mem_ready = 1'b1; out_rdy = 1'b0; resp_lat = 2;
    repeat (30) cycle();
    #1;
    checks++;
    if (q_count !== 4'd8 || bus.mem_req_valid !== 1'b0 || fire_count != 8) begin
      failures++;
      $display("FAIL fill: q_count=%0d valid=%b fires=%0d, required 8 / 0 / 8",
               q_count, bus.mem_req_valid, fire_count);
    end
    out_rdy = 1'b1;
    repeat (2) cycle();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q_count !== 4'd0 || bus.out_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: q_count=%0d out_valid=%b req_valid=%b, required 0/0/0",
               q_count, bus.out_valid, bus.mem_req_valid);
    end
  endtask

  task automatic test_redirect();
    int p0;
    do_reset();
    mem_ready = 1'b1; out_rdy = 1'b1; resp_lat = 6;
    repeat (3) cycle();
    mem_ready = 1'b0;
    cycle();
    redirect = 1'b1; redirect_pc = 32'h100; mem_ready = 1'b1;
    cycle();
    redirect = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.mem_req_addr !== 32'h100) begin
      failures++;
      $display("FAIL redirect_next: out_valid=%b addr=%h, required 0 / 00000100",
               bus.out_valid, bus.mem_req_addr);
    end
    p0 = pop_count;
    for (int i = 0; i < 40 && pop_count == p0; i++) cycle();
    checks++;
    if (pop_count == p0 || last_pop_pc !== 32'h100) begin
      failures++;
      $display("FAIL redirect_first: popped=%0d pc=%h, required first pc 00000100",
               pop_count - p0, last_pop_pc);
    end
    repeat (6) cycle();
  endtask

  task automatic test_redirect_collision();
    int p0;
    do_reset();
    mem_ready = 1'b1; out_rdy = 1'b1; resp_lat = 2;
    repeat (10) cycle();
    redirect = 1'b1; redirect_pc = 32'h200;
    cycle();
    redirect = 1'b0;
    #1;
    checks++;
    if (coll !== 1'b1) begin
      failures++;
      $display("FAIL collision_setup: resp+pop in redirect cycle=%b, required 1", coll);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || q_count !== 4'd0 || bus.mem_req_addr !== 32'h200) begin
      failures++;
      $display("FAIL collision_flush: out_valid=%b q_count=%0d addr=%h, required 0/0/00000200",
               bus.out_valid, q_count, bus.mem_req_addr);
    end
    p0 = pop_count;
    for (int i = 0; i < 40 && pop_count == p0; i++) cycle();
    checks++;
    if (pop_count == p0 || last_pop_pc !== 32'h200) begin
      failures++;
      $display("FAIL collision_first: popped=%0d pc=%h, required first pc 00000200",
               pop_count - p0, last_pop_pc);
    end
    repeat (6) cycle();
  endtask

  task automatic test_fault();
    int p0;
    do_reset();
    err_addr = 32'h8; mem_ready = 1'b1; out_rdy = 1'b1; resp_lat = 2;
    for (int i = 0; i < 40 && !exp_faulted; i++) cycle();
    checks++;
    if (exp_faulted !== 1'b1 || faulted !== 1'b1) begin
      failures++;
      $display("FAIL fault_entry: fault entry seen=%b faulted=%b, required 1/1",
               exp_faulted, faulted);
    end
    repeat (8) cycle();
    checks++;
    if (q_count !== 4'd0) begin
      failures++;
      $display("FAIL fault_drain: q_count=%0d, required 0", q_count);
    end
    redirect = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect = 1'b0;
    #1;
    checks++;
    if (faulted !== 1'b0 || bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h40) begin
      failures++;
      $display("FAIL fault_recover: faulted=%b valid=%b addr=%h, required 0/1/00000040",
               faulted, bus.mem_req_valid, bus.mem_req_addr);
    end
    p0 = pop_count;
    for (int i = 0; i < 40 && pop_count == p0; i++) cycle();
    checks++;
    if (pop_count == p0 || last_pop_pc !== 32'h40) begin
      failures++;
      $display("FAIL fault_resume: popped=%0d pc=%h, required first pc 00000040",
               pop_count - p0, last_pop_pc);
    end
  endtask

  task automatic test_stall();
    int f0;
    do_reset();
    mem_ready = 1'b0; out_rdy = 1'b1; resp_lat = 2;
    repeat (2) cycle();
    f0 = fire_count;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i >= 2);
      cycle();
      checks++;
      if (bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== 32'h0) begin
        failures++;
        $display("FAIL stall_hold: valid=%b addr=%h, required 0 / 00000000",
                 bus.mem_req_valid, bus.mem_req_addr);
      end
    end
    checks++;
    if (fire_count != f0) begin
      failures++;
      $display("FAIL stall_fire: fires=%0d during stall, required 0", fire_count - f0);
    end
    stall = 1'b0; mem_ready = 1'b1;
    cycle();
    checks++;
    if (fire_count != f0 + 1 || last_fire_addr !== 32'h0) begin
      failures++;
      $display("FAIL stall_resume: fires=%0d addr=%h, required 1 / 00000000",
               fire_count - f0, last_fire_addr);
    end
    repeat (8) cycle();
    checks++;
    if (pop_count < 4) begin
      failures++;
      $display("FAIL stall_pops: pops=%0d, required >=4", pop_count);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_redirect();
    test_redirect_collision();
    test_fault();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
